// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one negedge-clocked ALU between two requesters (req0, req1) using
//   round-robin arbitration. Each side has a valid/ready request port and a
//   valid/ready response port. Only one operation is in flight at a time:
//   IDLE (arbitrate/accept) -> ISSUE (ALU computes on the negedge) ->
//   RESP (hold result until consumed) -> IDLE.
//
// Parameters
//   WIDTH    operand/result width (must match the ALU)
//   IDLE_OP  ALUOp driven while no operation is in flight
//
// Ports
//   clock, reset_n              clock (posedge), asynchronous active-low reset
//   reqN_valid/ready            request handshake, N = 0,1
//   reqN_rs/rt/op               operands and op (01 ADD, 10 SUB, 11 AND, 00 NOP)
//   rspN_valid/ready/data       response handshake and result
//   rspN_ovf                    signed overflow flag (only with ALU_OVF_EN)
//   alu_rs/alu_rt/alu_op        registered operands/op driven to the ALU
//   alu_result                  ALU result (ALU updates it on the negedge)
//
// Build option
//   ALU_OVF_EN  when defined, adds rsp0_ovf/rsp1_ovf registered with the data.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int         WIDTH   = 32,
  parameter logic [1:0] IDLE_OP = 2'b00
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_rs,
  input  logic [WIDTH-1:0] req0_rt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_rs,
  input  logic [WIDTH-1:0] req1_rt,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
`ifdef ALU_OVF_EN
  output logic             rsp0_ovf,
  output logic             rsp1_ovf,
`endif
  output logic [WIDTH-1:0] alu_rs,
  output logic [WIDTH-1:0] alu_rt,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic owner_reg;       // requester that owns the in-flight operation
  logic last_grant_reg;  // most recent winner; the other side wins a tie
  logic grant;           // requester selected this cycle (valid when grant_valid)
  logic grant_valid;
  logic rsp_ready_owner;

  // Arbitration: a lone requester wins; on a tie the one that did not win last.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end else begin
      grant = req1_valid;
    end
  end

  assign rsp_ready_owner = owner_reg ? rsp1_ready : rsp0_ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (grant_valid) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_RESP;
      ST_RESP:  if (rsp_ready_owner) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: ready is only ever offered in IDLE, and only to the winner.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_reg == ST_IDLE && grant_valid) begin
      req0_ready = ~grant;
      req1_ready = grant;
    end
  end

`ifdef ALU_OVF_EN
  // Overflow is judged in ISSUE, where alu_rs/alu_rt/alu_op still hold the
  // captured operation and alu_result holds the ALU's answer for it.
  logic ovf_calc;
  always_comb begin
    ovf_calc = 1'b0;
    if (alu_op == OP_ADD) begin
      ovf_calc = (alu_rs[WIDTH-1] == alu_rt[WIDTH-1]) &&
                 (alu_result[WIDTH-1] != alu_rs[WIDTH-1]);
    end else if (alu_op == OP_SUB) begin
      ovf_calc = (alu_rs[WIDTH-1] != alu_rt[WIDTH-1]) &&
                 (alu_result[WIDTH-1] != alu_rs[WIDTH-1]);
    end
  end
`endif

  // Datapath: ALU operand registers, ownership, response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_rs         <= '0;
      alu_rt         <= '0;
      alu_op         <= IDLE_OP;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      rsp0_valid     <= 1'b0;
      rsp1_valid     <= 1'b0;
      rsp0_data      <= '0;
      rsp1_data      <= '0;
`ifdef ALU_OVF_EN
      rsp0_ovf       <= 1'b0;
      rsp1_ovf       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            alu_rs         <= grant ? req1_rs : req0_rs;
            alu_rt         <= grant ? req1_rt : req0_rt;
            alu_op         <= grant ? req1_op : req0_op;
            owner_reg      <= grant;
            last_grant_reg <= grant;
          end
        end
        ST_ISSUE: begin
          // The ALU sampled alu_* on the preceding negedge; take its result
          // and park the ALU on the idle op. Operands are left as they are.
          alu_op <= IDLE_OP;
          if (owner_reg) begin
            rsp1_data  <= alu_result;
            rsp1_valid <= 1'b1;
`ifdef ALU_OVF_EN
            rsp1_ovf   <= ovf_calc;
`endif
          end else begin
            rsp0_data  <= alu_result;
            rsp0_valid <= 1'b1;
`ifdef ALU_OVF_EN
            rsp0_ovf   <= ovf_calc;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready_owner) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. Contains a negedge-clocked ALU model
//   and a reference model of the expected results and arbitration order.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic         req_valid [2];
  logic         req_ready [2];
  logic [W-1:0] req_rs    [2];
  logic [W-1:0] req_rt    [2];
  logic [1:0]   req_op    [2];
  logic         rsp_valid [2];
  logic         rsp_ready [2];
  logic [W-1:0] rsp_data  [2];
`ifdef ALU_OVF_EN
  logic         rsp_ovf   [2];
`endif
  logic [W-1:0] alu_rs;
  logic [W-1:0] alu_rt;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_result = '0;

  int total = 0;
  int bad   = 0;
  bit last_winner = 1'b1;  // model: who won most recently (reset: req1)

  alu_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_rs    (req_rs[0]),
    .req0_rt    (req_rt[0]),
    .req0_op    (req_op[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_rs    (req_rs[1]),
    .req1_rt    (req_rt[1]),
    .req1_op    (req_op[1]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_data  (rsp_data[0]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_data  (rsp_data[1]),
`ifdef ALU_OVF_EN
    .rsp0_ovf   (rsp_ovf[0]),
    .rsp1_ovf   (rsp_ovf[1]),
`endif
    .alu_rs     (alu_rs),
    .alu_rt     (alu_rt),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  always #5 clock = ~clock;

  // External ALU: samples its inputs on the negedge.
  always @(negedge clock) begin
    case (alu_op)
      2'b01:   alu_result <= alu_rs + alu_rt;
      2'b10:   alu_result <= alu_rs - alu_rt;
      2'b11:   alu_result <= alu_rs & alu_rt;
      default: alu_result <= '0;
    endcase
  end

  // Reference: results from plain 64-bit arithmetic reduced modulo 2^32.
  function automatic logic [W-1:0] ref_result(input logic [1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint unsigned x = a;
    longint unsigned y = b;
    longint unsigned m = 64'd1 << W;
    longint unsigned r = 0;
    case (op)
      2'b01:   r = (x + y) % m;
      2'b10:   r = (x + m - y) % m;
      2'b11:   r = x & y;
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  // Reference: signed overflow = exact signed result outside the 32-bit range.
  function automatic bit ref_ovf(input logic [1:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint lim = 64'sh7FFFFFFF;
    longint s = 0;
    if (op == 2'b01) s = sa + sb;
    else if (op == 2'b10) s = sa - sb;
    else return 1'b0;
    return (s > lim) || (s < -lim - 1);
  endfunction

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int p, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_rs[p]    = a;
    req_rt[p]    = b;
  endtask

  // Waits (bounded) for ready on port p, completes the accepting edge.
  task automatic accept(input int p, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      cyc++;
      if (req_ready[p] === 1'b1) begin
        @(posedge clock);
        #1;
        req_valid[p] = 1'b0;
        last_winner  = p[0];
        ok = 1'b1;
      end
    end
    if (!ok) req_valid[p] = 1'b0;
  endtask

  // Waits (bounded) for a response on port p, stalls, then consumes it.
  task automatic get_rsp(input int p, input int stall, output logic [W-1:0] data,
                         output bit ovf, output int cyc, output bit ok);
    ok   = 1'b0;
    cyc  = 0;
    data = '0;
    ovf  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      cyc++;
      if (rsp_valid[p] === 1'b1) ok = 1'b1;
    end
    if (!ok) return;
    repeat (stall) @(negedge clock);
    data = rsp_data[p];
`ifdef ALU_OVF_EN
    ovf = rsp_ovf[p];
`endif
    rsp_ready[p] = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0;
      rsp_ready[p] = 1'b0;
    end
    @(negedge clock);
    reset_n = 1'b1;
    last_winner = 1'b1;
  endtask

  task automatic test_reset();
    int cyc;
    bit ok;
    bit seen;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (req_ready[0] !== 1'b0 || req_ready[1] !== 1'b0 || rsp_valid[0] !== 1'b0 ||
        rsp_valid[1] !== 1'b0 || rsp_data[0] !== '0 || rsp_data[1] !== '0 ||
        alu_rs !== '0 || alu_rt !== '0 || alu_op !== 2'b00) begin
      bad++;
      $display("FAIL reset_state got rdy=%b%b vld=%b%b d0=%h d1=%h rs=%h rt=%h op=%b want all zero",
               req_ready[0], req_ready[1], rsp_valid[0], rsp_valid[1], rsp_data[0],
               rsp_data[1], alu_rs, alu_rt, alu_op);
    end
    @(negedge clock);
    reset_n = 1'b1;
    last_winner = 1'b1;
    // Reset in the middle of ISSUE
    sync();
    set_req(0, 2'b01, 32'd5, 32'd6);
    accept(0, cyc, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reset_accept got timeout want accepted");
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (alu_op !== 2'b00 || alu_rs !== '0 || alu_rt !== '0 || rsp_valid[0] !== 1'b0 ||
        rsp_data[0] !== '0 || req_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_issue got op=%b rs=%h rt=%h vld=%b d=%h rdy=%b want zeros",
               alu_op, alu_rs, alu_rt, rsp_valid[0], rsp_data[0], req_ready[0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    last_winner = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid[0] !== 1'b0 || rsp_valid[1] !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_discard got rsp_valid=1 want no response after reset");
    end
  endtask

  task automatic test_single();
    int cyc_a, cyc_r;
    bit ok_a, ok_r, ovf;
    logic [W-1:0] d;
    sync();
    set_req(0, 2'b01, 32'd5, 32'd7);
    accept(0, cyc_a, ok_a);
    get_rsp(0, 0, d, ovf, cyc_r, ok_r);
    total++;
    if (!ok_a || cyc_a != 1) begin
      bad++;
      $display("FAIL single_ready got ok=%0d cyc=%0d want ok=1 cyc=1", ok_a, cyc_a);
    end
    total++;
    if (!ok_r || cyc_r != 2) begin
      bad++;
      $display("FAIL single_latency got ok=%0d cyc=%0d want ok=1 cyc=2", ok_r, cyc_r);
    end
    total++;
    if (d !== 32'd12) begin
      bad++;
      $display("FAIL single_data got %h want %h", d, 32'd12);
    end
  endtask

  task automatic test_contention();
    int cyc;
    bit ok, ovf;
    logic [W-1:0] d;
    do_reset();
    sync();
    set_req(0, 2'b10, 32'd10, 32'd3);
    set_req(1, 2'b11, 32'hF0, 32'h3C);
    @(negedge clock);
    total++;
    if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL contention_first got rdy0=%b rdy1=%b want rdy0=1 rdy1=0",
               req_ready[0], req_ready[1]);
    end
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    last_winner  = 1'b0;
    get_rsp(0, 0, d, ovf, cyc, ok);
    total++;
    if (!ok || d !== 32'd7) begin
      bad++;
      $display("FAIL contention_rsp0 got ok=%0d d=%h want 00000007", ok, d);
    end
    // req1 still waiting; req0 comes back at once -> req1 must win now.
    set_req(0, 2'b01, 32'd2, 32'd3);
    @(negedge clock);
    total++;
    if (req_ready[1] !== 1'b1 || req_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL contention_second got rdy0=%b rdy1=%b want rdy0=0 rdy1=1",
               req_ready[0], req_ready[1]);
    end
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    last_winner  = 1'b1;
    get_rsp(1, 1, d, ovf, cyc, ok);
    total++;
    if (!ok || d !== 32'h30) begin
      bad++;
      $display("FAIL contention_rsp1 got ok=%0d d=%h want 00000030", ok, d);
    end
    accept(0, cyc, ok);
    get_rsp(0, 0, d, ovf, cyc, ok);
    total++;
    if (!ok || d !== 32'd5) begin
      bad++;
      $display("FAIL contention_rsp0b got ok=%0d d=%h want 00000005", ok, d);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok, ovf;
    logic [W-1:0] d;
    sync();
    set_req(1, 2'b01, 32'd1, 32'd1);
    accept(1, cyc, ok);
    set_req(0, 2'b01, 32'd3, 32'd4);
    @(negedge clock);
    total++;
    if (req_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_issue_ready got %b want 0", req_ready[0]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'd2 || req_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d got vld=%b d=%h rdy0=%b want vld=1 d=00000002 rdy0=0",
                 i, rsp_valid[1], rsp_data[1], req_ready[0]);
      end
    end
    rsp_ready[1] = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready[1] = 1'b0;
    total++;
    if (rsp_valid[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got vld=%b want 0", rsp_valid[1]);
    end
    @(negedge clock);
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_next_ready got %b want 1", req_ready[0]);
    end
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    last_winner  = 1'b0;
    get_rsp(0, 0, d, ovf, cyc, ok);
    total++;
    if (!ok || d !== 32'd7) begin
      bad++;
      $display("FAIL bp_rsp0 got ok=%0d d=%h want 00000007", ok, d);
    end
  endtask

  task automatic test_wrap_nop();
    logic [1:0]   ops  [3] = '{2'b01, 2'b00, 2'b10};
    logic [W-1:0] as   [3] = '{32'hFFFFFFFF, 32'd9, 32'd0};
    logic [W-1:0] bs   [3] = '{32'd1, 32'd4, 32'd1};
    logic [W-1:0] want [3] = '{32'h0, 32'h0, 32'hFFFFFFFF};
    int cyc;
    bit ok, ovf;
    logic [W-1:0] d;
    for (int i = 0; i < 3; i++) begin
      sync();
      set_req(i % 2, ops[i], as[i], bs[i]);
      accept(i % 2, cyc, ok);
      get_rsp(i % 2, 0, d, ovf, cyc, ok);
      total++;
      if (!ok || cyc != 2 || d !== want[i]) begin
        bad++;
        $display("FAIL wrap_nop case %0d got ok=%0d cyc=%0d d=%h want cyc=2 d=%h",
                 i, ok, cyc, d, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_d [2];
    bit           exp_o [2];
    int cyc;
    bit ok, ovf, w;
    logic [W-1:0] d;
    logic [1:0] pend;
    for (int r = 0; r < 16; r++) begin
      sync();
      pend = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          set_req(p, 2'($urandom_range(0, 3)), $urandom, $urandom);
          if ($urandom_range(0, 3) == 0) req_rt[p] = req_rs[p];
          exp_d[p] = ref_result(req_op[p], req_rs[p], req_rt[p]);
          exp_o[p] = ref_ovf(req_op[p], req_rs[p], req_rt[p]);
        end
      end
      while (pend != 2'b00) begin
        w = (pend == 2'b11) ? ~last_winner : pend[1];
        @(negedge clock);
        total++;
        if (req_ready[w] !== 1'b1 || req_ready[~w] !== 1'b0) begin
          bad++;
          $display("FAIL random_grant round %0d got rdy0=%b rdy1=%b want winner=%0d",
                   r, req_ready[0], req_ready[1], w);
        end
        @(posedge clock);
        #1;
        req_valid[w] = 1'b0;
        last_winner  = w;
        pend[w]      = 1'b0;
        get_rsp(w, $urandom_range(0, 3), d, ovf, cyc, ok);
        total++;
        if (!ok || d !== exp_d[w]) begin
          bad++;
          $display("FAIL random_data round %0d port %0d got ok=%0d d=%h want %h",
                   r, w, ok, d, exp_d[w]);
        end
`ifdef ALU_OVF_EN
        total++;
        if (ovf !== exp_o[w]) begin
          bad++;
          $display("FAIL random_ovf round %0d port %0d got %b want %b", r, w, ovf, exp_o[w]);
        end
`else
        if (exp_o[w] && ovf) $display("note: overflow flag not built");
`endif
      end
    end
  endtask

`ifdef ALU_OVF_EN
  task automatic test_ovf();
    logic [1:0]   ops  [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [W-1:0] as   [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd1};
    logic [W-1:0] bs   [4] = '{32'd1, 32'd1, 32'hFFFFFFFF, 32'd1};
    logic [W-1:0] want [4] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd2};
    bit           wovf [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int cyc;
    bit ok, ovf;
    logic [W-1:0] d;
    for (int i = 0; i < 4; i++) begin
      sync();
      set_req(i % 2, ops[i], as[i], bs[i]);
      accept(i % 2, cyc, ok);
      get_rsp(i % 2, 0, d, ovf, cyc, ok);
      total++;
      if (!ok || d !== want[i] || ovf !== wovf[i]) begin
        bad++;
        $display("FAIL ovf case %0d got ok=%0d d=%h ovf=%b want d=%h ovf=%b",
                 i, ok, d, ovf, want[i], wovf[i]);
      end
    end
  endtask
`endif

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0;
      req_rs[p]    = '0;
      req_rt[p]    = '0;
      req_op[p]    = 2'b00;
      rsp_ready[p] = 1'b0;
    end
    reset_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap_nop();
    test_random();
`ifdef ALU_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
